// File: rtl/cdda_i2s_serializer.sv
// cdda_i2s_serializer: left-justified stereo serializer for 16-bit CDDA sample pairs.
// Generates bck/sd/lrck from clk and pulses consume once per sample pair loaded.
module cdda_i2s_serializer #(
   parameter int unsigned CLK_FREQUENCY = 33868800,
   parameter int unsigned SAMPLE_RATE   = 44100,
   parameter int unsigned SLOT_BITS     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enabled,
   input  logic [15:0] left,
   input  logic [15:0] right,
   output logic        bck,
   output logic        sd,
   output logic        lrck,
   output logic        consume
);

   localparam int unsigned FRAME_DIV  = SAMPLE_RATE * 4 * SLOT_BITS;
   localparam int unsigned HALF_DIV   = CLK_FREQUENCY / FRAME_DIV;
   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned DW         = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int unsigned BW         = $clog2(FRAME_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_IDX = BW'(SLOT_BITS);

   if ((HALF_DIV < 1) || (HALF_DIV * FRAME_DIV != CLK_FREQUENCY)) begin : g_bad_div
      $error("cdda_i2s_serializer: CLK_FREQUENCY not an exact multiple of 4*SLOT_BITS*SAMPLE_RATE");
   end
   if ((SLOT_BITS < 16) || (SLOT_BITS > 32)) begin : g_bad_slot
      $error("cdda_i2s_serializer: SLOT_BITS must be within 16..32");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state, state_n;
   logic [DW-1:0]           div, div_n;
   logic [BW-1:0]           bitidx, bitidx_n;
   logic [FRAME_BITS-1:0]   shreg, shreg_n, load_word;
   logic                    bck_n, sd_n, lrck_n, consume_n;
   logic                    load;

   // Frame image: each sample MSB-aligned in its slot, trailing slot bits zero.
   always_comb begin
      load_word = '0;
      load_word[FRAME_BITS-1 -: 16] = left;
      load_word[SLOT_BITS-1 -: 16]  = right;
   end

   // Next-state and output logic; a load edge overrides everything else.
   always_comb begin
      state_n   = state;
      div_n     = div;
      bitidx_n  = bitidx;
      shreg_n   = shreg;
      bck_n     = bck;
      sd_n      = sd;
      lrck_n    = lrck;
      consume_n = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            div_n    = '0;
            bitidx_n = '0;
            bck_n    = 1'b0;
            sd_n     = 1'b0;
            lrck_n   = 1'b0;
            if (enabled) load = 1'b1;
         end
         RUN: begin
            if (div != DIV_LAST) begin
               div_n = div + DW'(1);
            end else begin
               div_n = '0;
               if (!bck) begin
                  bck_n = 1'b1;
               end else if (bitidx == LAST_IDX) begin
                  // Frame boundary: either chain straight into the next frame or stop cleanly.
                  if (enabled) begin
                     load = 1'b1;
                  end else begin
                     state_n  = IDLE;
                     bck_n    = 1'b0;
                     sd_n     = 1'b0;
                     lrck_n   = 1'b0;
                     bitidx_n = '0;
                     shreg_n  = '0;
                  end
               end else begin
                  bck_n    = 1'b0;
                  bitidx_n = bitidx + BW'(1);
                  shreg_n  = shreg << 1;
                  sd_n     = shreg[FRAME_BITS-2];
                  lrck_n   = (bitidx_n < SLOT_IDX);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (load) begin
         state_n   = RUN;
         shreg_n   = load_word;
         div_n     = '0;
         bitidx_n  = '0;
         bck_n     = 1'b0;
         lrck_n    = 1'b1;
         sd_n      = left[15];
         consume_n = 1'b1;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         div     <= '0;
         bitidx  <= '0;
         shreg   <= '0;
         bck     <= 1'b0;
         sd      <= 1'b0;
         lrck    <= 1'b0;
         consume <= 1'b0;
      end else begin
         state   <= state_n;
         div     <= div_n;
         bitidx  <= bitidx_n;
         shreg   <= shreg_n;
         bck     <= bck_n;
         sd      <= sd_n;
         lrck    <= lrck_n;
         consume <= consume_n;
      end
   end

endmodule
